// File: rtl/handshake_tx_arbiter_pkg.sv
// handshake_tx_arbiter_pkg: shared FSM encoding and tag-width helper for the
// transmit-side handshake arbiter.
package handshake_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_LAUNCH = 2'b01,
    ARB_WAIT   = 2'b10
  } arb_state_e;

  // Minimum number of bits needed to encode n distinct indices (at least 1).
  function automatic int unsigned tag_bits(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 1; i < 32; i++) begin
      if (w == 0 && (32'd1 << i) >= n) w = i;
    end
    return w;
  endfunction

endpackage

// File: rtl/handshake_tx_arbiter_picker.sv
// rr_priority_picker: combinational round-robin winner selection.
// Searches last_i+1 .. last_i+N (modulo N) and returns the first set request
// both as a one-hot vector and as a binary index.
module rr_priority_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] index_o,
  output logic          valid_o
);

  int unsigned idx;
  logic        found;

  // Rotating first-hit search starting just after the last winner.
  always_comb begin
    onehot_o = '0;
    index_o  = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = (32'(last_i) + off) % N;
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        onehot_o[idx] = 1'b1;
        index_o       = IW'(idx);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/handshake_tx_arbiter.sv
// handshake_tx_arbiter: shares one handshake_synchronizer between CHANNELS
// requesters in the transmit clock domain. The granted word is tagged with
// its channel index and held stable until the four-phase handshake finishes.
// Build option: HANDSHAKE_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins
// priority instead of round-robin.
module handshake_tx_arbiter
  import handshake_tx_arbiter_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned CH_WIDTH    = 2
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic [CHANNELS-1:0]             Req,
  input  logic [CHANNELS*WORD_LENGTH-1:0] Req_data,
  output logic [CHANNELS-1:0]             Grant,
  output logic [CHANNELS-1:0]             Done,
  output logic                            Busy,
  output logic [CH_WIDTH+WORD_LENGTH-1:0] Sync_tx_data,
  output logic                            Sync_send,
  input  logic                            Sync_sending,
  input  logic                            Sync_data_sent
);

  localparam int unsigned DW = CH_WIDTH + WORD_LENGTH;

  if (CHANNELS < 2) begin : g_bad_channels
    $error("handshake_tx_arbiter: CHANNELS must be >= 2");
  end
  if (WORD_LENGTH == 0) begin : g_bad_word
    $error("handshake_tx_arbiter: WORD_LENGTH must be > 0");
  end
  if (CH_WIDTH < tag_bits(CHANNELS)) begin : g_bad_tag
    $error("handshake_tx_arbiter: CH_WIDTH too small for CHANNELS");
  end

  arb_state_e                 state_q, state_d;
  logic [CHANNELS-1:0]        grant_q, grant_d;
  logic [CHANNELS-1:0]        done_q, done_d;
  logic [CHANNELS-1:0]        cur_q, cur_d;
  logic                       busy_q, busy_d;
  logic                       send_q, send_d;
  logic [DW-1:0]              data_q, data_d;

  logic [CH_WIDTH-1:0]        ptr_last;
  logic [CHANNELS-1:0]        pick_onehot;
  logic [CH_WIDTH-1:0]        pick_idx;
  logic                       pick_valid;
  logic [WORD_LENGTH-1:0]     pick_word;

`ifdef HANDSHAKE_ARB_FIXED_PRIO_EN
  // Pinning the search start at CHANNELS-1 makes channel 0 always searched first.
  assign ptr_last = CH_WIDTH'(CHANNELS - 1);
`else
  logic [CH_WIDTH-1:0]        last_q, last_d;

  assign ptr_last = last_q;

  // Round-robin pointer: index of the most recently completed channel.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) last_q <= CH_WIDTH'(CHANNELS - 1);
    else       last_q <= last_d;
  end

  // Pointer advances only when a transfer completes.
  always_comb begin
    last_d = last_q;
    if (state_q == ARB_WAIT && Sync_data_sent) last_d = data_q[DW-1 -: CH_WIDTH];
  end
`endif

  rr_priority_picker #(
    .N  (CHANNELS),
    .IW (CH_WIDTH)
  ) u_picker (
    .req_i    (Req),
    .last_i   (ptr_last),
    .onehot_o (pick_onehot),
    .index_o  (pick_idx),
    .valid_o  (pick_valid)
  );

  // Payload mux driven by the one-hot winner.
  always_comb begin
    pick_word = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (pick_onehot[k]) pick_word = Req_data[k*WORD_LENGTH +: WORD_LENGTH];
    end
  end

  // Next-state and registered-output logic for the transfer FSM.
  always_comb begin
    state_d = state_q;
    grant_d = '0;
    done_d  = '0;
    send_d  = 1'b0;
    cur_d   = cur_q;
    busy_d  = busy_q;
    data_d  = data_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid && !Sync_sending) begin
          grant_d = pick_onehot;
          cur_d   = pick_onehot;
          data_d  = {pick_idx, pick_word};
          busy_d  = 1'b1;
          state_d = ARB_LAUNCH;
        end
      end
      ARB_LAUNCH: begin
        send_d  = 1'b1;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (Sync_data_sent) begin
          done_d  = cur_q;
          busy_d  = 1'b0;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      cur_q   <= '0;
      busy_q  <= 1'b0;
      send_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      cur_q   <= cur_d;
      busy_q  <= busy_d;
      send_q  <= send_d;
      data_q  <= data_d;
    end
  end

  assign Grant        = grant_q;
  assign Done         = done_q;
  assign Busy         = busy_q;
  assign Sync_send    = send_q;
  assign Sync_tx_data = data_q;

endmodule

// File: tb/tb_handshake_tx_arbiter.sv
// tb_handshake_tx_arbiter: directed bench for handshake_tx_arbiter; the
// synchronizer side (Sync_sending / Sync_data_sent) is driven by hand.
module tb_handshake_tx_arbiter;

  localparam int unsigned CH = 4;
  localparam int unsigned WL = 8;
  localparam int unsigned CW = 2;

  logic              Clock = 1'b0;
  logic              Reset;
  logic [CH-1:0]     Req;
  logic [CH*WL-1:0]  Req_data;
  logic [CH-1:0]     Grant;
  logic [CH-1:0]     Done;
  logic              Busy;
  logic [CW+WL-1:0]  Sync_tx_data;
  logic              Sync_send;
  logic              Sync_sending;
  logic              Sync_data_sent;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  handshake_tx_arbiter #(
    .CHANNELS    (CH),
    .WORD_LENGTH (WL),
    .CH_WIDTH    (CW)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Req            (Req),
    .Req_data       (Req_data),
    .Grant          (Grant),
    .Done           (Done),
    .Busy           (Busy),
    .Sync_tx_data   (Sync_tx_data),
    .Sync_send      (Sync_send),
    .Sync_sending   (Sync_sending),
    .Sync_data_sent (Sync_data_sent)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic set_word(input int unsigned k, input logic [7:0] w);
    Req_data[k*WL +: WL] = w;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".grant"}, 32'(Grant), 32'h0);
    check_eq({tag, ".done"},  32'(Done), 32'h0);
    check_eq({tag, ".busy"},  32'(Busy), 32'h0);
    check_eq({tag, ".send"},  32'(Sync_send), 32'h0);
    check_eq({tag, ".data"},  32'(Sync_tx_data), 32'h0);
  endtask

  // One complete transfer; Req must already request so the next edge grants.
  task automatic xfer(input string tag, input logic [3:0] exp_g, input logic [9:0] exp_d,
                      input logic [3:0] req_after);
    tick;
    check_eq({tag, ".grant"}, 32'(Grant), 32'(exp_g));
    check_eq({tag, ".data"},  32'(Sync_tx_data), 32'(exp_d));
    check_eq({tag, ".busy"},  32'(Busy), 32'h1);
    check_eq({tag, ".send0"}, 32'(Sync_send), 32'h0);
    Req = req_after;
    tick;
    check_eq({tag, ".send1"}, 32'(Sync_send), 32'h1);
    check_eq({tag, ".gnt_off"}, 32'(Grant), 32'h0);
    Sync_sending = 1'b1;
    tick;
    check_eq({tag, ".send_off"}, 32'(Sync_send), 32'h0);
    check_eq({tag, ".hold"}, 32'(Sync_tx_data), 32'(exp_d));
    check_eq({tag, ".no_done"}, 32'(Done), 32'h0);
    Sync_data_sent = 1'b1;
    tick;
    check_eq({tag, ".done"}, 32'(Done), 32'(exp_g));
    check_eq({tag, ".busy_off"}, 32'(Busy), 32'h0);
    Sync_data_sent = 1'b0;
    Sync_sending   = 1'b0;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    #1;
    check_idle_outputs("reset");
    tick;
    Reset = 1'b0;
  endtask

  initial begin
    Reset          = 1'b1;
    Req            = '0;
    Req_data       = '0;
    Sync_sending   = 1'b0;
    Sync_data_sent = 1'b0;
    set_word(0, 8'h5A);
    set_word(1, 8'h3C);
    set_word(2, 8'hA5);
    set_word(3, 8'h77);
    #1;
    check_idle_outputs("por");
    tick;
    tick;
    Reset = 1'b0;

    // Scenario 1: single request on channel 2
    Req = 4'b0100;
    xfer("s1", 4'b0100, 10'h2A5, 4'b0000);

`ifndef HANDSHAKE_ARB_FIXED_PRIO_EN
    // Scenario 2: all channels held, strict rotation from channel 0
    do_reset;
    for (int unsigned k = 0; k < CH; k++) set_word(k, 8'h10 + 8'(k));
    Req = 4'b1111;
    xfer("s2.c0", 4'b0001, 10'h010, 4'b1111);
    xfer("s2.c1", 4'b0010, 10'h111, 4'b1111);
    xfer("s2.c2", 4'b0100, 10'h212, 4'b1111);
    xfer("s2.c3", 4'b1000, 10'h313, 4'b1111);
    xfer("s2.c0b", 4'b0001, 10'h010, 4'b0000);
`else
    // Scenario 3: fixed priority, lowest index always wins
    do_reset;
    for (int unsigned k = 0; k < CH; k++) set_word(k, 8'h10 + 8'(k));
    Req = 4'b1111;
    xfer("s3.a0", 4'b0001, 10'h010, 4'b1111);
    xfer("s3.a1", 4'b0001, 10'h010, 4'b1111);
    xfer("s3.a2", 4'b0001, 10'h010, 4'b1110);
    xfer("s3.b0", 4'b0010, 10'h111, 4'b1110);
    xfer("s3.b1", 4'b0010, 10'h111, 4'b0000);
`endif
    set_word(0, 8'h5A);
    set_word(1, 8'h3C);
    set_word(2, 8'hA5);
    set_word(3, 8'h77);

    // Scenario 4: reset during WAIT_SENT loses the word, no Done
    Req = 4'b0100;
    tick;
    check_eq("s4.grant", 32'(Grant), 32'h4);
    Req = 4'b0000;
    tick;
    Sync_sending = 1'b1;
    tick;
    check_eq("s4.busy_wait", 32'(Busy), 32'h1);
    Reset = 1'b1;
    #1;
    check_idle_outputs("s4.async");
    Sync_sending = 1'b0;
    tick;
    Reset = 1'b0;
    Sync_data_sent = 1'b1;
    tick;
    check_eq("s4.no_done", 32'(Done), 32'h0);
    check_eq("s4.no_grant", 32'(Grant), 32'h0);
    Sync_data_sent = 1'b0;
    Req = 4'b0001;
    xfer("s4.after", 4'b0001, 10'h05A, 4'b0000);

    // Scenario 5: data_sent in IDLE ignored; Sync_sending blocks grants
    Sync_data_sent = 1'b1;
    tick;
    check_eq("s5.idle_done", 32'(Done), 32'h0);
    Sync_data_sent = 1'b0;
    Sync_sending = 1'b1;
    Req = 4'b0010;
    tick;
    check_eq("s5.blk_g0", 32'(Grant), 32'h0);
    check_eq("s5.blk_busy", 32'(Busy), 32'h0);
    tick;
    check_eq("s5.blk_g1", 32'(Grant), 32'h0);
    Sync_sending = 1'b0;
    xfer("s5.go", 4'b0010, 10'h13C, 4'b0000);

    // data_sent seen during LAUNCH must not complete the transfer
    Req = 4'b0001;
    tick;
    check_eq("s5.l_grant", 32'(Grant), 32'h1);
    Req = 4'b0000;
    Sync_data_sent = 1'b1;
    tick;
    check_eq("s5.l_send", 32'(Sync_send), 32'h1);
    check_eq("s5.l_nodone", 32'(Done), 32'h0);
    Sync_data_sent = 1'b0;
    Sync_sending = 1'b1;
    tick;
    check_eq("s5.l_nodone2", 32'(Done), 32'h0);
    check_eq("s5.l_busy", 32'(Busy), 32'h1);
    Sync_data_sent = 1'b1;
    tick;
    check_eq("s5.l_done", 32'(Done), 32'h1);
    Sync_data_sent = 1'b0;
    Sync_sending = 1'b0;

    // Scenario 6: Req[3] dropped right after Grant, Done still pulses
    Req = 4'b1000;
    xfer("s6", 4'b1000, 10'h377, 4'b0000);

    // Single requester served on consecutive free slots
    Req = 4'b0100;
    xfer("s7.a", 4'b0100, 10'h2A5, 4'b0100);
    xfer("s7.b", 4'b0100, 10'h2A5, 4'b0000);
    tick;
    check_eq("s7.quiet", 32'(Grant), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
